cpu_bus_fabric: RTL and testbench

- Parametrised address decoder and read-return mux between the 6502 core bus (AB/DI/DO/WE/RDY) and N memory-mapped slaves (RAM, ROMs, PIF RAM, controller, N64 interface regs, CRC).
- Replaces hand-written casez decode with table-driven base/mask regions.
- Adds registered return-path select, a per-access stall timeout and an unmapped-address error response, captured in sticky error registers for debug.

---
 rtl/cpu_bus_pkg.sv | 24 ++
 rtl/cpu_bus_timeout.sv | 36 +++
 rtl/cpu_bus_fabric.sv | 148 ++++++++++++++
 tb/tb_cpu_bus_fabric.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared constants, error encodings and decode helpers for the CPU bus fabric
package cpu_bus_pkg;

  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

  typedef enum logic {
    ERR_TIMEOUT  = 1'b0,
    ERR_UNMAPPED = 1'b1
  } err_kind_e;

  // Address bits outside the mask are don't-care for the region.
  function automatic logic region_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
    return ((addr ^ base) & mask) == 32'd0;
  endfunction

  function automatic int clog2(input int value);
    int w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/cpu_bus_timeout.sv
// rtl/cpu_bus_timeout.sv - stall cycle counter that forces completion after TIMEOUT stalled cycles
module cpu_bus_timeout
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic restart,
  output logic force_ready
);

  localparam int CNT_W = clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A reset landing on the terminal count must not complete the access.
  always_comb begin
    force_ready = !reset && stall && (cnt_q == CNT_W'(TIMEOUT - 1));
    cnt_d       = cnt_q + CNT_W'(1);
    if (restart || !stall || force_ready) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_bus_fabric.sv
// rtl/cpu_bus_fabric.sv - table-driven address decode and registered read-return mux for the 6502 bus
module cpu_bus_fabric
  import cpu_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES    = 8,
  parameter int                           ADDR_W        = 16,
  parameter int                           DATA_W        = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE      = {NUM_SLAVES{ADDR_W'(16'h0000)}},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK      = {NUM_SLAVES{ADDR_W'(16'hF000)}},
  parameter int                           DEFAULT_SLAVE = NUM_SLAVES,
  parameter int                           TIMEOUT       = 64,
  parameter logic [DATA_W-1:0]            ERR_DATA      = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         cpu_we,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic [NUM_SLAVES-1:0]        slv_ce,
  output logic [NUM_SLAVES-1:0]        slv_we,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_valid,
  input  logic                         err_clr,
  output logic                         bus_err,
  output logic                         bus_err_kind,
  output logic [ADDR_W-1:0]            bus_err_addr
);

  localparam int SEL_W = clog2(NUM_SLAVES + 1);

  logic [SEL_W-1:0]  sel;
  logic              unmapped;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              unmapped_q, unmapped_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              act_q, act_d;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_rdata;
  logic              stall;
  logic              force_ready;
  logic              err_event;
  logic              bus_err_q, bus_err_d;
  err_kind_e         bus_err_kind_q, bus_err_kind_d;
  logic [ADDR_W-1:0] bus_err_addr_q, bus_err_addr_d;

  // Descending scan so the lowest matching index wins on overlap.
  always_comb begin
    sel = SEL_W'(DEFAULT_SLAVE);
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (region_match(32'(cpu_addr), 32'(SLV_BASE[i*ADDR_W +: ADDR_W]),
                       32'(SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
        sel = SEL_W'(i);
      end
    end
    unmapped = (sel >= SEL_W'(NUM_SLAVES));
  end

  always_comb begin
    slv_ce = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slv_ce[i] = !reset && !unmapped && (sel == SEL_W'(i));
    end
    slv_we    = slv_ce & {NUM_SLAVES{cpu_we}};
    slv_addr  = cpu_addr;
    slv_wdata = cpu_wdata;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_valid = slv_valid[i];
        sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
      end
    end
    stall = act_q && !unmapped_q && !sel_valid;
  end

  cpu_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .restart     (cpu_addr != addr_q),
    .force_ready (force_ready)
  );

  always_comb begin
    cpu_ready = act_q && (unmapped_q || sel_valid || force_ready);
    cpu_rdata = '0;
    if (act_q) begin
      cpu_rdata = (unmapped_q || force_ready) ? ERR_DATA : sel_rdata;
    end
  end

  always_comb begin
    sel_d      = sel;
    unmapped_d = unmapped;
    addr_d     = cpu_addr;
    act_d      = 1'b1;
  end

  // An error coinciding with err_clr re-captures instead of being lost.
  always_comb begin
    err_event      = !reset && act_q && (unmapped_q || force_ready);
    bus_err_d      = bus_err_q;
    bus_err_kind_d = bus_err_kind_q;
    bus_err_addr_d = bus_err_addr_q;
    if (err_event && (!bus_err_q || err_clr)) begin
      bus_err_d      = 1'b1;
      bus_err_kind_d = unmapped_q ? ERR_UNMAPPED : ERR_TIMEOUT;
      bus_err_addr_d = addr_q;
    end else if (err_clr) begin
      bus_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q          <= '0;
      unmapped_q     <= 1'b0;
      addr_q         <= '0;
      act_q          <= 1'b0;
      bus_err_q      <= 1'b0;
      bus_err_kind_q <= ERR_TIMEOUT;
      bus_err_addr_q <= '0;
    end else begin
      sel_q          <= sel_d;
      unmapped_q     <= unmapped_d;
      addr_q         <= addr_d;
      act_q          <= act_d;
      bus_err_q      <= bus_err_d;
      bus_err_kind_q <= bus_err_kind_d;
      bus_err_addr_q <= bus_err_addr_d;
    end
  end

  assign bus_err      = bus_err_q;
  assign bus_err_kind = bus_err_kind_q;
  assign bus_err_addr = bus_err_addr_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb/tb_cpu_bus_fabric.sv - self-checking bench for cpu_bus_fabric
module tb_cpu_bus_fabric;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [7:0]  slv_ce;
  logic [7:0]  slv_we;
  logic [15:0] slv_addr;
  logic [7:0]  slv_wdata;
  logic [63:0] slv_rdata;
  logic [7:0]  slv_valid = 8'hFF;
  logic        err_clr = 1'b0;
  logic        bus_err;
  logic        bus_err_kind;
  logic [15:0] bus_err_addr;

  logic [7:0]  sdata [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) slv_rdata[i*8 +: 8] = sdata[i];
  end

  cpu_bus_fabric #(
    .NUM_SLAVES    (8),
    .ADDR_W        (16),
    .DATA_W        (8),
    .SLV_BASE      ({16'h7000, 16'h6000, 16'h5000, 16'h4000,
                     16'h3000, 16'h2000, 16'h1000, 16'h0000}),
    .SLV_MASK      ({8{16'hF000}}),
    .DEFAULT_SLAVE (8),
    .TIMEOUT       (64),
    .ERR_DATA      (8'hFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .slv_ce       (slv_ce),
    .slv_we       (slv_we),
    .slv_addr     (slv_addr),
    .slv_wdata    (slv_wdata),
    .slv_rdata    (slv_rdata),
    .slv_valid    (slv_valid),
    .err_clr      (err_clr),
    .bus_err      (bus_err),
    .bus_err_kind (bus_err_kind),
    .bus_err_addr (bus_err_addr)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  exp_ce;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // Reference error state: sticky first-error capture with clear.
  logic        m_err = 1'b0;
  logic        m_kind = 1'b0;
  logic [15:0] m_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d,
                     input logic [7:0] v, input logic c, input logic r);
    @(negedge clk);
    cpu_addr  = a;
    cpu_we    = w;
    cpu_wdata = d;
    slv_valid = v;
    err_clr   = c;
    reset     = r;
    #1;
  endtask

  task automatic model_err(input logic ev, input logic kind, input logic [15:0] ad, input logic clr);
    if (ev && (!m_err || clr)) begin
      m_err  = 1'b1;
      m_kind = kind;
      m_addr = ad;
    end else if (clr) begin
      m_err = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] a, prev_a;
  logic        we, clr, mapped, prev_unm;
  logic [7:0]  d, exp_ce, vlow;
  logic [3:0]  s;
  int          w, got, highs;
  logic [7:0]  got_data;

  initial begin
    sdata = '{8'h3C, 8'h5A, 8'h69, 8'h96, 8'hA5, 8'hC3, 8'h0F, 8'hF0};
    vecs[0] = '{16'h1234, 1'b0, 8'h00, 8'h02, 8'h5A};
    vecs[1] = '{16'h0456, 1'b1, 8'hA5, 8'h01, 8'h3C};
    vecs[2] = '{16'h2FFF, 1'b0, 8'h00, 8'h04, 8'h69};
    vecs[3] = '{16'h7000, 1'b1, 8'h5C, 8'h80, 8'hF0};
    vecs[4] = '{16'h4ABC, 1'b0, 8'h00, 8'h10, 8'hA5};
    vecs[5] = '{16'h3001, 1'b0, 8'h00, 8'h08, 8'h96};

    // reset state
    cyc(16'h1234, 1'b1, 8'h55, 8'hFF, 1'b0, 1'b1);
    cyc(16'h1234, 1'b1, 8'h55, 8'hFF, 1'b0, 1'b1);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_ce", slv_ce, 0);
    chk("rst_we", slv_we, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_kind", bus_err_kind, 0);
    chk("rst_eaddr", bus_err_addr, 0);

    // table-driven single-cycle accesses
    for (int i = 0; i < 6; i++) begin
      cyc(vecs[i].addr, vecs[i].we, vecs[i].wdata, 8'hFF, 1'b0, 1'b0);
      chk("vec_ce", slv_ce, vecs[i].exp_ce);
      chk("vec_we", slv_we, vecs[i].we ? vecs[i].exp_ce : 8'h00);
      chk("vec_addr", slv_addr, vecs[i].addr);
      chk("vec_wdata", slv_wdata, vecs[i].wdata);
      cyc(vecs[i].addr, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
      chk("vec_ready", cpu_ready, 1);
      chk("vec_rdata", cpu_rdata, vecs[i].exp_rdata);
    end

    // slave2 withholds valid for three cycles
    cyc(16'h2100, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b0);
    chk("st3_ce", slv_ce, 8'h04);
    for (int k = 0; k < 3; k++) begin
      cyc(16'h2100, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b0);
      chk("st3_low", cpu_ready, 0);
    end
    cyc(16'h2100, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("st3_ready", cpu_ready, 1);
    chk("st3_rdata", cpu_rdata, 8'h69);
    cyc(16'h0010, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("st3_noerr", bus_err, 0);

    // slave2 never valid: forced completion on the 64th stall cycle
    cyc(16'h2345, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b0);
    got = 0;
    got_data = 8'h00;
    for (int k = 1; k <= 80; k++) begin
      cyc(16'h2345, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b0);
      if (cpu_ready) begin
        got = k;
        got_data = cpu_rdata;
        break;
      end
    end
    chk("to_cycle", got, 64);
    chk("to_rdata", got_data, 8'hFF);
    cyc(16'h0010, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("to_err", bus_err, 1);
    chk("to_kind", bus_err_kind, 0);
    chk("to_eaddr", bus_err_addr, 16'h2345);

    // unmapped accesses; error plus err_clr in one cycle re-captures
    cyc(16'hF000, 1'b1, 8'h77, 8'hFF, 1'b0, 1'b0);
    chk("um_ce", slv_ce, 0);
    chk("um_we", slv_we, 0);
    cyc(16'hE000, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
    chk("um_ready", cpu_ready, 1);
    chk("um_rdata", cpu_rdata, 8'hFF);
    cyc(16'h0010, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("um_err", bus_err, 1);
    chk("um_kind", bus_err_kind, 1);
    chk("um_eaddr", bus_err_addr, 16'hF000);
    chk("um2_rdata", cpu_rdata, 8'hFF);
    cyc(16'h0010, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
    chk("um2_eaddr", bus_err_addr, 16'hF000);
    cyc(16'h0010, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("clr_err", bus_err, 0);

    // reset lands exactly where the timeout would fire
    cyc(16'h2200, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b0);
    highs = 0;
    for (int k = 1; k <= 63; k++) begin
      cyc(16'h2200, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b0);
      if (cpu_ready) highs++;
    end
    chk("rs_low", highs, 0);
    cyc(16'h2200, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b1);
    chk("rs_noforce", cpu_ready, 0);
    cyc(16'h2200, 1'b0, 8'h00, 8'hFB, 1'b0, 1'b1);
    chk("rs_ce", slv_ce, 0);
    chk("rs_ready", cpu_ready, 0);
    chk("rs_rdata", cpu_rdata, 0);
    chk("rs_err", bus_err, 0);
    cyc(16'h1111, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("rs_ce2", slv_ce, 8'h02);
    cyc(16'h1111, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("rs_ready2", cpu_ready, 1);
    chk("rs_rdata2", cpu_rdata, 8'h5A);
    cyc(16'h1111, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("rs_err2", bus_err, 0);

    // randomized accesses against the reference model
    m_err = 1'b0;
    prev_unm = 1'b0;
    prev_a = 16'h1111;
    for (int t = 0; t < 60; t++) begin
      a   = 16'($urandom);
      we  = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      w   = $urandom_range(0, 3);
      clr = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 8; i++) sdata[i] = 8'($urandom);
      s      = a[15:12];
      mapped = (s < 4'd8);
      exp_ce = mapped ? 8'(1 << s) : 8'h00;
      vlow   = (mapped && w > 0) ? ~exp_ce : 8'hFF;

      cyc(a, we, d, vlow, clr, 1'b0);
      chk("rnd_err", bus_err, m_err);
      if (m_err) begin
        chk("rnd_kind", bus_err_kind, m_kind);
        chk("rnd_eaddr", bus_err_addr, m_addr);
      end
      chk("rnd_ce", slv_ce, exp_ce);
      chk("rnd_we", slv_we, we ? exp_ce : 8'h00);
      model_err(prev_unm, 1'b1, prev_a, clr);

      if (mapped) begin
        for (int k = 0; k < w; k++) begin
          cyc(a, we, d, vlow, 1'b0, 1'b0);
          chk("rnd_stall", cpu_ready, 0);
        end
      end
      cyc(a, we, d, 8'hFF, 1'b0, 1'b0);
      chk("rnd_ready", cpu_ready, 1);
      chk("rnd_rdata", cpu_rdata, mapped ? sdata[s[2:0]] : 8'hFF);
      model_err(!mapped, 1'b1, a, 1'b0);
      prev_unm = !mapped;
      prev_a = a;
    end
    cyc(16'h0010, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
    chk("rnd_final_err", bus_err, m_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
